// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU encoding: opcodes, ALU functions, instruction field positions
package cpu_pkg;

  localparam int INSTR_BITS = 16;

  localparam logic [2:0] OP_RTYPE = 3'd0;
  localparam logic [2:0] OP_ITYPE = 3'd1;
  localparam logic [2:0] OP_LOAD  = 3'd2;
  localparam logic [2:0] OP_STORE = 3'd3;
  localparam logic [2:0] OP_JUMP  = 3'd4;
  localparam logic [2:0] OP_BEZ   = 3'd5;
  localparam logic [2:0] OP_BNEZ  = 3'd6;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 13;
  localparam int RD_MSB  = 12;
  localparam int RD_LSB  = 10;
  localparam int RS1_MSB = 9;
  localparam int RS1_LSB = 7;
  localparam int RS2_MSB = 6;
  localparam int RS2_LSB = 4;
  localparam int FN_MSB  = 3;
  localparam int FN_LSB  = 0;
  localparam int IMM_MSB = 6;

  // 7-bit immediate widened to the 8-bit datapath immediate
  function automatic logic [7:0] sext_imm(input logic [INSTR_BITS-1:0] instr);
    return {instr[IMM_MSB], instr[IMM_MSB:0]};
  endfunction

endpackage

// File: rtl/instr_fields.sv
// rtl/instr_fields.sv - combinational split of an instruction word into decode fields
module instr_fields
  import cpu_pkg::*;
(
  input  logic [INSTR_BITS-1:0] instr_i,
  output logic [2:0]            main_op_o,
  output logic [3:0]            alu_in_o,
  output logic [2:0]            rd_o,
  output logic [2:0]            rs1_o,
  output logic [2:0]            rs2_o,
  output logic [7:0]            imm_o
);

  assign main_op_o = instr_i[OP_MSB:OP_LSB];
  assign alu_in_o  = instr_i[FN_MSB:FN_LSB];
  assign rd_o      = instr_i[RD_MSB:RD_LSB];
  assign rs1_o     = instr_i[RS1_MSB:RS1_LSB];
  assign rs2_o     = instr_i[RS2_MSB:RS2_LSB];
  assign imm_o     = sext_imm(instr_i);

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch FSM and program counter
// FETCH -> WAIT -> ISSUE -> FETCH, or HALT when the controller withholds en_pc.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter int PC_W    = 8,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_valid,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               issue_valid,
  output logic [2:0]         main_op,
  output logic [3:0]         alu_in,
  output logic [2:0]         rd,
  output logic [2:0]         rs1,
  output logic [2:0]         rs2,
  output logic [7:0]         imm,
  input  logic               en_pc,
  input  logic               jump,
  input  logic               pcsrc,
  output logic               halted,
  output logic [PC_W-1:0]    pc
);

  localparam logic [1:0] S_FETCH = 2'd0;
  localparam logic [1:0] S_WAIT  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_HALT  = 2'd3;

  localparam logic [PC_W-1:0] PC_ONE = 1;

  logic [1:0]         state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic               req_q, req_d;

  instr_fields u_fields (
    .instr_i   (ir_q),
    .main_op_o (main_op),
    .alu_in_o  (alu_in),
    .rd_o      (rd),
    .rs1_o     (rs1),
    .rs2_o     (rs2),
    .imm_o     (imm)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_FETCH: state_d = S_WAIT;
      S_WAIT: begin
        if (imem_valid && req_q) begin
          ir_d    = imem_data;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (en_pc) begin
          state_d = S_FETCH;
          if (!jump) begin
            pc_d = pc_q + PC_ONE;
          end else if (pcsrc) begin
            pc_d = PC_W'(ir_q);
          end else begin
            pc_d = pc_q + PC_ONE + PC_W'($signed(imm));
          end
        end else begin
          state_d = S_HALT;
        end
      end
      default: state_d = S_HALT;
    endcase
    // Request is registered so it first rises on the edge after reset release
    req_d = (state_d == S_FETCH) || (state_d == S_WAIT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      req_q   <= req_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign issue_valid = (state_q == S_ISSUE);
  assign halted      = (state_q == S_HALT);

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_valid;
  logic [15:0] imem_data;
  logic        issue_valid;
  logic [2:0]  main_op;
  logic [3:0]  alu_in;
  logic [2:0]  rd, rs1, rs2;
  logic [7:0]  imm;
  logic        en_pc, jump, pcsrc;
  logic        halted;
  logic [7:0]  pc;

  fetch_unit #(.PC_W(8), .INSTR_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data),
    .issue_valid(issue_valid), .main_op(main_op), .alu_in(alu_in),
    .rd(rd), .rs1(rs1), .rs2(rs2), .imm(imm),
    .en_pc(en_pc), .jump(jump), .pcsrc(pcsrc),
    .halted(halted), .pc(pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] instr;
    int          dly;
    bit          en;
    bit          j;
    bit          src;
    int          exp_next;
  } vec_t;

  vec_t       tbl [12];
  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (imem_req === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_req", imem_req, 0);
    chk("rst_issue", issue_valid, 0);
    chk("rst_halted", halted, 0);
    chk("rst_addr", imem_addr, 0);
    chk("rst_pc", pc, 0);
  endtask

  // One full fetch/issue transaction; exp_next < 0 selects the reference model
  task automatic do_txn(input logic [15:0] instr, input int dly, input bit en,
                        input bit j, input bit src, input int exp_next);
    bit ok;
    int immv;
    int nxt;
    wait_req(ok);
    chk("req_timeout", ok, 1);
    if (!ok) return;
    chk("fetch_addr", imem_addr, exp_pc);
    chk("fetch_issue", issue_valid, 0);
    for (int k = 0; k <= dly; k++) begin
      @(negedge clk);
      chk("wait_req", imem_req, 1);
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_issue", issue_valid, 0);
    end
    imem_valid = 1'b1;
    imem_data  = instr;
    @(negedge clk);
    imem_valid = 1'($urandom_range(0, 1));
    imem_data  = 16'($urandom);
    chk("issue_valid", issue_valid, 1);
    chk("main_op", main_op, instr[15:13]);
    chk("alu_in", alu_in, instr[3:0]);
    chk("rd", rd, instr[12:10]);
    chk("rs1", rs1, instr[9:7]);
    chk("rs2", rs2, instr[6:4]);
    chk("imm", imm, {instr[6], instr[6:0]});
    en_pc = en;
    jump  = j;
    pcsrc = src;
    immv = instr[6] ? int'(instr[6:0]) - 128 : int'(instr[6:0]);
    if (!en)      nxt = int'(exp_pc);
    else if (!j)  nxt = (int'(exp_pc) + 1) % 256;
    else if (src) nxt = int'(instr[7:0]);
    else          nxt = (int'(exp_pc) + 1 + immv + 256) % 256;
    exp_pc = (exp_next >= 0) ? 8'(exp_next) : 8'(nxt);
    @(negedge clk);
    imem_valid = 1'b0;
    en_pc = 1'($urandom);
    jump  = 1'($urandom);
    pcsrc = 1'($urandom);
    chk("issue_once", issue_valid, 0);
    chk("halted_after", halted, !en);
    chk("pc_after", pc, exp_pc);
    if (!en) chk("halt_req", imem_req, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    tbl[0]  = '{16'h0000, 0, 1, 0, 0, 1};
    tbl[1]  = '{16'h0000, 0, 1, 0, 0, 2};
    tbl[2]  = '{16'h0000, 0, 1, 0, 0, 3};
    tbl[3]  = '{16'h8005, 1, 1, 1, 1, 5};
    tbl[4]  = '{16'h800A, 0, 1, 1, 1, 10};
    tbl[5]  = '{16'hA07E, 7, 1, 1, 0, 9};
    tbl[6]  = '{16'h800A, 2, 1, 1, 1, 10};
    tbl[7]  = '{16'hA07E, 0, 1, 0, 1, 11};
    tbl[8]  = '{16'h80FF, 0, 1, 1, 1, 255};
    tbl[9]  = '{16'h0000, 3, 1, 0, 0, 0};
    tbl[10] = '{16'h5B40, 1, 1, 1, 0, 193};
    tbl[11] = '{16'hE000, 0, 0, 1, 1, 193};

    rst_n = 1'b1;
    imem_valid = 1'b0;
    imem_data  = 16'h0;
    en_pc = 1'b0;
    jump  = 1'b0;
    pcsrc = 1'b0;
    #1 rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 8'd0;
    @(negedge clk);
    chk("first_req", imem_req, 1);
    chk("first_addr", imem_addr, 0);

    foreach (tbl[i])
      do_txn(tbl[i].instr, tbl[i].dly, tbl[i].en, tbl[i].j, tbl[i].src, tbl[i].exp_next);

    // Halt is terminal: stray valids and controller inputs change nothing
    for (int c = 0; c < 10; c++) begin
      imem_valid = 1'($urandom);
      imem_data  = 16'($urandom);
      en_pc = 1'b1;
      jump  = 1'($urandom);
      @(negedge clk);
      chk("halt_hold", halted, 1);
      chk("halt_noreq", imem_req, 0);
      chk("halt_noissue", issue_valid, 0);
      chk("halt_pc", pc, 193);
    end
    imem_valid = 1'b0;

    rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = 8'd0;
    @(negedge clk);
    chk("restart_req", imem_req, 1);
    chk("restart_addr", imem_addr, 0);
    do_txn(16'h0000, 0, 1, 0, 0, -1);

    // Reset during WAIT, then the abandoned read's data turns up late
    wait_req(ok);
    chk("mw_req", ok, 1);
    chk("mw_addr", imem_addr, 1);
    @(negedge clk);
    rst_n = 1'b0;
    #1 check_reset_outputs();
    @(negedge clk);
    rst_n = 1'b1;
    imem_valid = 1'b1;
    imem_data  = 16'h8055;
    @(negedge clk);
    imem_valid = 1'b0;
    chk("mw_noissue0", issue_valid, 0);
    chk("mw_req_again", imem_req, 1);
    chk("mw_addr0", imem_addr, 0);
    @(negedge clk);
    chk("mw_noissue1", issue_valid, 0);
    exp_pc = 8'd0;
    do_txn(16'h0000, 0, 1, 0, 0, -1);

    for (int r = 0; r < 40; r++)
      do_txn(16'($urandom), $urandom_range(0, 3), 1'b1,
             1'($urandom), 1'($urandom), -1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter PC_W, 8, program counter width in bits (word-addressed).
REQ-002 Parameter INSTR_W, 16, instruction width; fixed at 16 for the current encoding.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 imem_req  output  1  instruction-memory read request.
REQ-006 imem_addr  output  PC_W  read address, equal to the PC.
REQ-007 imem_valid  input  1  read data valid; accepted only while imem_req=1.
REQ-008 imem_data  input  16  instruction word.
REQ-009 issue_valid  output  1  decoded fields are valid this cycle.
REQ-010 main_op  output  3  instr[15:13]; 0 RTYPE, 1 ITYPE, 2 LOAD, 3 STORE, 4 JUMP, 5 BEZ, 6 BNEZ.
REQ-011 alu_in  output  4  instr[3:0] (RTYPE function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR).
REQ-012 rd, rs1, rs2  output  3 each  instr[12:10], instr[9:7], instr[6:4].
REQ-013 imm  output  8  sign-extended instr[6:0].
REQ-014 en_pc, jump, pcsrc  input  1 each  controller feedback, sampled only in the ISSUE state.
REQ-015 halted  output  1  fetch stopped after an illegal opcode.
REQ-016 pc  output  PC_W  current program counter.

Function
REQ-017 The FSM SHALL have four states: FETCH, WAIT, ISSUE, HALT.
REQ-018 FETCH SHALL assert imem_req with imem_addr=pc and move to WAIT on the next cycle.
REQ-019 WAIT SHALL hold imem_req=1 and imem_addr stable until imem_valid=1; WAIT length is unbounded.
REQ-020 On imem_valid=1 in WAIT, the unit SHALL latch imem_data into the instruction register and move to ISSUE; the total latency is 1 cycle after the valid cycle.
REQ-021 ISSUE SHALL last exactly one cycle with issue_valid=1; all decoded outputs SHALL derive from the instruction register, not from imem_data.
REQ-022 PC update in ISSUE: if en_pc=1 and jump=0, pc SHALL become pc+1.
REQ-023 If en_pc=1, jump=1 and pcsrc=1, pc SHALL become zero-extended instr[PC_W-1:0] (absolute jump).
REQ-024 If en_pc=1, jump=1 and pcsrc=0, pc SHALL become pc+1+imm (relative branch).
REQ-025 Following any PC update in ISSUE, the next state SHALL be FETCH.
REQ-026 If en_pc=0 in ISSUE, pc SHALL hold, the next state SHALL be HALT, and halted SHALL be set to 1.
REQ-027 All PC arithmetic SHALL be modulo 2^PC_W; pc=2^PC_W-1 plus 1 SHALL wrap to 0 without a flag.
REQ-028 HALT SHALL be terminal until reset, with imem_req=0 and issue_valid=0.
REQ-029 imem_valid arriving outside WAIT SHALL be ignored.
REQ-030 issue_valid SHALL be 0 in every state except ISSUE; decoded outputs are don't-care when it is 0.

Reset
REQ-031 rst_n=0 SHALL immediately force pc=0, the instruction register to 0, state=FETCH, imem_req=0, issue_valid=0 and halted=0.
REQ-032 Reset asserted mid-WAIT or mid-ISSUE SHALL abandon the transaction; any later imem_valid for it SHALL be ignored.
REQ-033 The first imem_req SHALL assert in the first clock edge after rst_n deasserts, with imem_addr=0.

Structure
REQ-034 Opcode and ALU-function constants and the instruction field positions SHALL live in the shared cpu package, which the controller also uses.
REQ-035 The decode logic SHALL be one combinational sub-module, instr_fields, that splits the instruction register into the field outputs; the FSM and PC SHALL be in fetch_unit.

Verification
REQ-036 Reset, then memory returns 0x0000 one cycle after each request -> requests at addr 0, 1, 2; issue_valid pulses once per instruction; main_op=0.
REQ-037 Instruction 0x8005 (JUMP, target 5) issued with en_pc=1, jump=1, pcsrc=1 -> next imem_addr=5.
REQ-038 BEZ with imm=-2 at pc=10, jump=1, pcsrc=0 -> next imem_addr=9; with jump=0 -> next imem_addr=11.
REQ-039 imem_valid delayed 7 cycles -> imem_req and imem_addr stay constant, issue_valid stays 0 until one cycle after valid.
REQ-040 Opcode 7 issued with en_pc=0 -> halted=1 and imem_req=0 permanently; rst_n pulse -> fetch restarts at addr 0.
REQ-041 pc=255 with sequential flow -> next imem_addr=0; rst_n asserted during WAIT followed by a late imem_valid -> no issue; fetch restarts at 0.
